// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the MEM stage: access sizes, FSM states,
// byte-lane selection and load extension.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  // off is the already-aligned byte offset within the word
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: lane_mask = 4'b0001 << off;
      SZ_HALF: lane_mask = off[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] off, input logic uns);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (size)
      SZ_BYTE: load_extend = {{24{~uns & sh[7]}}, sh[7:0]};
      SZ_HALF: load_extend = {{16{~uns & sh[15]}}, sh[15:0]};
      default: load_extend = word;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_be.sv
// Synchronous word memory with per-byte write enables and a registered read port.
// Read-before-write: a read on the same edge as a write returns the old contents.
module data_mem_be #(
  parameter int AW = 9
) (
  input  logic          clock,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [0:(1<<AW)-1];
  logic [31:0] rdata_q;

  always_ff @(posedge clock) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: sized loads/stores on a byte-enabled memory with MEM_LAT-cycle access.
// Optional MEM_ACC_MISALIGN_TRAP_EN flags misaligned half/word accesses instead of masking.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 11,
  parameter int MEM_LAT = 1,
  parameter int RD_W    = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       in_data,
  input  logic              wb_entrada,
  input  logic [RD_W-1:0]   ex_mem_register_rd,
  output logic              stall,
  output logic              wb_valid,
  output logic              wb_salida,
  output logic [RD_W-1:0]   mem_wb_register_rd,
  output logic [31:0]       mem_data,
  output logic [31:0]       ex_data,
  output logic              misaligned
);

  localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);
  localparam bit         MULTI    = (MEM_LAT > 1);

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            is_mem, complete, bad_align;
  logic [1:0]      off_aln;
  logic [3:0]      we;
  logic [31:0]     wdata, rdata;

  logic            wb_valid_q, wb_valid_d, wb_salida_q, wb_salida_d;
  logic [RD_W-1:0] rd_q, rd_d;
  logic [31:0]     ex_data_q, ex_data_d;
  logic            load_q, load_d, uns_q, uns_d, mis_q, mis_d;
  logic [1:0]      size_q, size_d, off_q, off_d;

  always_comb begin
    is_mem = mem_read | mem_write;
    case (mem_size)
      SZ_BYTE: begin off_aln = address[1:0];       wdata = {4{in_data[7:0]}};  end
      SZ_HALF: begin off_aln = {address[1], 1'b0}; wdata = {2{in_data[15:0]}}; end
      default: begin off_aln = 2'b00;              wdata = in_data;            end
    endcase
`ifdef MEM_ACC_MISALIGN_TRAP_EN
    bad_align = is_mem && ((mem_size == SZ_HALF) ? address[0]
                           : ((mem_size != SZ_BYTE) && (address[1:0] != 2'b00)));
`else
    bad_align = 1'b0;
`endif

    state_d  = state_q;
    cnt_d    = cnt_q;
    stall    = 1'b0;
    complete = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ex_valid) begin
          if (is_mem && MULTI) begin
            state_d = ST_BUSY;
            cnt_d   = CNT_LOAD;
            stall   = 1'b1;
          end else begin
            complete = 1'b1;
          end
        end
      end
      default: begin
        // Completion happens in the cycle whose decrement brings the counter to 0,
        // giving MEM_LAT cycles from acceptance to the MEM/WB register.
        cnt_d = cnt_q - 4'd1;
        if (cnt_d == 4'd0) begin
          complete = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
    endcase

    we = (complete && mem_write && !bad_align && !reset) ? lane_mask(mem_size, off_aln) : 4'b0000;

    wb_valid_d  = complete;
    wb_salida_d = complete & wb_entrada & ~bad_align;
    rd_d        = ex_mem_register_rd;
    ex_data_d   = in_data;
    load_d      = complete & mem_read & ~mem_write & ~bad_align;
    size_d      = mem_size;
    off_d       = off_aln;
    uns_d       = mem_unsigned;
    mis_d       = complete & bad_align;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      wb_valid_q  <= 1'b0;
      wb_salida_q <= 1'b0;
      rd_q        <= '0;
      ex_data_q   <= 32'd0;
      load_q      <= 1'b0;
      size_q      <= 2'b00;
      off_q       <= 2'b00;
      uns_q       <= 1'b0;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wb_valid_q  <= wb_valid_d;
      wb_salida_q <= wb_salida_d;
      rd_q        <= rd_d;
      ex_data_q   <= ex_data_d;
      load_q      <= load_d;
      size_q      <= size_d;
      off_q       <= off_d;
      uns_q       <= uns_d;
      mis_q       <= mis_d;
    end
  end

  data_mem_be #(.AW(ADDR_W - 2)) u_mem (
    .clock (clock),
    .we    (we),
    .addr  (address[ADDR_W-1:2]),
    .wdata (wdata),
    .rdata (rdata)
  );

  // The RAM output register doubles as the load-data stage; extension follows it.
  assign mem_data           = load_q ? load_extend(rdata, size_q, off_q, uns_q) : 32'd0;
  assign wb_valid           = wb_valid_q;
  assign wb_salida          = wb_salida_q;
  assign mem_wb_register_rd = rd_q;
  assign ex_data            = ex_data_q;
  assign misaligned         = mis_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: three instances (MEM_LAT 1, 3, 4) against a byte-array model.
module tb_mem_access_stage;

`ifdef MEM_ACC_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct packed {
    logic        vld;
    logic        wbs;
    logic [4:0]  rd;
    logic [31:0] md;
    logic [31:0] ed;
    logic        mis;
  } exp_t;

  logic clock, reset;
  logic        ex_valid [3];
  logic        mem_read [3];
  logic        mem_write [3];
  logic [1:0]  mem_size [3];
  logic        mem_uns [3];
  logic [10:0] addr [3];
  logic [31:0] in_data [3];
  logic        wb_in [3];
  logic [4:0]  rd_in [3];
  logic        stall_o [3];
  logic        wb_valid_o [3];
  logic        wb_salida_o [3];
  logic [4:0]  rd_o [3];
  logic [31:0] mem_data_o [3];
  logic [31:0] ex_data_o [3];
  logic        mis_o [3];

  exp_t pend [3];
  exp_t cur [3];
  bit   exp_stall [3];
  int   stall_cnt [3];
  logic [7:0] mem_m [3][2048];
  bit   cmp_en;
  int   checks, failures;

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 4);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_access_stage #(.ADDR_W(11), .MEM_LAT((g == 0) ? 1 : ((g == 1) ? 3 : 4)), .RD_W(5)) u_dut (
      .clock              (clock),
      .reset              (reset),
      .ex_valid           (ex_valid[g]),
      .mem_read           (mem_read[g]),
      .mem_write          (mem_write[g]),
      .mem_size           (mem_size[g]),
      .mem_unsigned       (mem_uns[g]),
      .address            (addr[g]),
      .in_data            (in_data[g]),
      .wb_entrada         (wb_in[g]),
      .ex_mem_register_rd (rd_in[g]),
      .stall              (stall_o[g]),
      .wb_valid           (wb_valid_o[g]),
      .wb_salida          (wb_salida_o[g]),
      .mem_wb_register_rd (rd_o[g]),
      .mem_data           (mem_data_o[g]),
      .ex_data            (ex_data_o[g]),
      .misaligned         (mis_o[g])
    );
  end

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s inst%0d got=%h exp=%h @%0t", nm, i, got, exp, $time);
    end
  endtask

  // Model: little-endian byte memory; access aligned down to its natural size.
  task automatic model_access(input int i, input bit rd, input bit wr, input logic [1:0] sz,
                              input bit uns, input logic [10:0] a, input logic [31:0] d,
                              input bit wbe, input logic [4:0] rdi, output exp_t e);
    int nb, base;
    bit mis;
    logic [31:0] v;
    nb   = (sz == 2'b00) ? 1 : ((sz == 2'b01) ? 2 : 4);
    base = int'(a) & ~(nb - 1);
    mis  = TRAP && (rd || wr) && (int'(a) % nb != 0);
    v    = 32'd0;
    if (rd && !wr && !mis) begin
      for (int b = 0; b < nb; b++) v[8*b +: 8] = mem_m[i][base + b];
      if (!uns && nb < 4 && v[8*nb - 1]) v = v | ~((32'h1 << (8*nb)) - 32'h1);
    end
    if (wr && !mis) begin
      for (int b = 0; b < nb; b++) mem_m[i][base + b] = d[8*b +: 8];
    end
    e.vld = 1'b1;
    e.wbs = wbe && !mis;
    e.rd  = rdi;
    e.md  = v;
    e.ed  = d;
    e.mis = mis;
  endtask

  task automatic op(input int i, input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                    input logic [10:0] a, input logic [31:0] d, input bit wbe, input logic [4:0] rdi);
    int   n;
    exp_t e;
    ex_valid[i] = 1'b1; mem_read[i] = rd; mem_write[i] = wr; mem_size[i] = sz;
    mem_uns[i] = uns; addr[i] = a; in_data[i] = d; wb_in[i] = wbe; rd_in[i] = rdi;
    n = (rd || wr) ? lat_of(i) - 1 : 0;
    for (int k = 0; k < n; k++) begin
      exp_stall[i] = 1'b1;
      @(posedge clock); #1;
    end
    exp_stall[i] = 1'b0;
    model_access(i, rd, wr, sz, uns, a, d, wbe, rdi, e);
    pend[i] = e;
    @(posedge clock); #1;
    ex_valid[i] = 1'b0; mem_read[i] = 1'b0; mem_write[i] = 1'b0; wb_in[i] = 1'b0;
  endtask

  always @(posedge clock) begin
    for (int i = 0; i < 3; i++) begin
      cur[i]  = pend[i];
      pend[i] = '0;
    end
  end

  always @(negedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (stall_o[i] === 1'b1) stall_cnt[i]++;
      if (cmp_en) begin
        chk("stall", i, {31'd0, stall_o[i]}, {31'd0, exp_stall[i]});
        chk("wb_valid", i, {31'd0, wb_valid_o[i]}, {31'd0, cur[i].vld});
        chk("wb_salida", i, {31'd0, wb_salida_o[i]}, {31'd0, cur[i].vld & cur[i].wbs});
        if (cur[i].vld) begin
          chk("rd", i, {27'd0, rd_o[i]}, {27'd0, cur[i].rd});
          chk("mem_data", i, mem_data_o[i], cur[i].md);
          chk("ex_data", i, ex_data_o[i], cur[i].ed);
          chk("misaligned", i, {31'd0, mis_o[i]}, {31'd0, cur[i].mis});
        end
      end
    end
  end

  task automatic chk_zero(input string nm, input int i);
    chk({nm, "_wb_valid"}, i, {31'd0, wb_valid_o[i]}, 32'd0);
    chk({nm, "_wb_salida"}, i, {31'd0, wb_salida_o[i]}, 32'd0);
    chk({nm, "_rd"}, i, {27'd0, rd_o[i]}, 32'd0);
    chk({nm, "_mem_data"}, i, mem_data_o[i], 32'd0);
    chk({nm, "_ex_data"}, i, ex_data_o[i], 32'd0);
    chk({nm, "_misaligned"}, i, {31'd0, mis_o[i]}, 32'd0);
  endtask

  initial begin
    int s0;
    checks = 0; failures = 0; cmp_en = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ex_valid[i] = 1'b0; mem_read[i] = 1'b0; mem_write[i] = 1'b0; mem_size[i] = 2'b00;
      mem_uns[i] = 1'b0; addr[i] = '0; in_data[i] = '0; wb_in[i] = 1'b0; rd_in[i] = '0;
      pend[i] = '0; cur[i] = '0; exp_stall[i] = 1'b0; stall_cnt[i] = 0;
    end
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_zero("reset", i);
      chk("reset_stall", i, {31'd0, stall_o[i]}, 32'd0);
    end
    cmp_en = 1'b1;

    // MEM_LAT=1: word store/load, extension, sub-word merge
    op(0, 0, 1, 2'b10, 0, 11'h010, 32'hDEADBEEF, 0, 5'd0);
    op(0, 1, 0, 2'b10, 0, 11'h010, 32'h0, 1, 5'd5);
    chk("lw_lat1", 0, mem_data_o[0], 32'hDEADBEEF);
    op(0, 0, 1, 2'b10, 0, 11'h020, 32'h80FF7F01, 0, 5'd0);
    op(0, 1, 0, 2'b00, 0, 11'h023, 32'h0, 1, 5'd1);
    chk("lb", 0, mem_data_o[0], 32'hFFFFFF80);
    op(0, 1, 0, 2'b00, 1, 11'h023, 32'h0, 1, 5'd2);
    chk("lbu", 0, mem_data_o[0], 32'h00000080);
    op(0, 1, 0, 2'b01, 0, 11'h022, 32'h0, 1, 5'd3);
    chk("lh", 0, mem_data_o[0], 32'hFFFF80FF);
    op(0, 1, 0, 2'b01, 1, 11'h020, 32'h0, 1, 5'd4);
    chk("lhu", 0, mem_data_o[0], 32'h00007F01);
    op(0, 0, 1, 2'b10, 0, 11'h030, 32'h0, 0, 5'd0);
    op(0, 0, 1, 2'b00, 0, 11'h031, 32'h000000AB, 0, 5'd0);
    op(0, 0, 1, 2'b01, 0, 11'h032, 32'h00001234, 0, 5'd0);
    op(0, 1, 0, 2'b10, 0, 11'h030, 32'h0, 1, 5'd6);
    chk("merge", 0, mem_data_o[0], 32'h1234AB00);
    op(0, 0, 0, 2'b00, 0, 11'h000, 32'h00000055, 1, 5'd7);
    chk("alu_ex_data", 0, ex_data_o[0], 32'h00000055);
    op(0, 1, 1, 2'b10, 0, 11'h050, 32'h00000077, 1, 5'd8);
    chk("rdwr_mem_data", 0, mem_data_o[0], 32'h0);
    op(0, 1, 0, 2'b10, 0, 11'h050, 32'h0, 1, 5'd9);
    chk("rdwr_stored", 0, mem_data_o[0], 32'h00000077);

    // Misaligned word store
    op(0, 0, 1, 2'b10, 0, 11'h040, 32'h11111111, 0, 5'd0);
    op(0, 0, 1, 2'b10, 0, 11'h041, 32'hCAFEF00D, 1, 5'd10);
    chk("mis_flag", 0, {31'd0, mis_o[0]}, {31'd0, TRAP});
    chk("mis_wb_salida", 0, {31'd0, wb_salida_o[0]}, {31'd0, !TRAP});
    op(0, 1, 0, 2'b10, 0, 11'h040, 32'h0, 1, 5'd11);
    chk("mis_mem", 0, mem_data_o[0], TRAP ? 32'h11111111 : 32'hCAFEF00D);

    // MEM_LAT=3: store, then a load followed directly by a non-memory op
    op(1, 0, 1, 2'b10, 0, 11'h010, 32'hA5A50102, 0, 5'd0);
    s0 = stall_cnt[1];
    op(1, 1, 0, 2'b01, 1, 11'h012, 32'h0, 1, 5'd12);
    chk("lat3_data", 1, mem_data_o[1], 32'h0000A5A5);
    chk("lat3_stall_cycles", 1, 32'(stall_cnt[1] - s0), 32'd2);
    op(1, 0, 0, 2'b00, 0, 11'h000, 32'h0BADF00D, 1, 5'd13);
    chk("lat3_alu", 1, ex_data_o[1], 32'h0BADF00D);

    // MEM_LAT=4: reset while busy aborts the store
    op(2, 0, 1, 2'b10, 0, 11'h040, 32'h11223344, 0, 5'd0);
    ex_valid[2] = 1'b1; mem_read[2] = 1'b0; mem_write[2] = 1'b1; mem_size[2] = 2'b10;
    addr[2] = 11'h040; in_data[2] = 32'h5; wb_in[2] = 1'b0; rd_in[2] = 5'd14;
    exp_stall[2] = 1'b1;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    ex_valid[2] = 1'b0; mem_write[2] = 1'b0;
    exp_stall[2] = 1'b0;
    chk_zero("abort", 2);
    op(2, 1, 0, 2'b10, 0, 11'h040, 32'h0, 1, 5'd15);
    chk("abort_mem", 2, mem_data_o[2], 32'h11223344);

    repeat (3) @(posedge clock);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
